// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports and the shared memory command/response port.
// The arbiter uses the slave view; the environment (requesters + memory) the master view.
interface mem_port_arbiter_if;
    logic        req0_valid;
    logic        req0_write;
    logic        req0_signed;
    logic [1:0]  req0_size;
    logic [31:0] req0_addr;
    logic [31:0] req0_wdata;
    logic        req0_ready;
    logic        req0_done;
    logic [31:0] req0_rdata;
    logic [2:0]  req0_fault;

    logic        req1_valid;
    logic        req1_write;
    logic        req1_signed;
    logic [1:0]  req1_size;
    logic [31:0] req1_addr;
    logic [31:0] req1_wdata;
    logic        req1_ready;
    logic        req1_done;
    logic [31:0] req1_rdata;
    logic [2:0]  req1_fault;

    logic        m_en;
    logic        m_write;
    logic        m_signed;
    logic [1:0]  m_size;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_busy;
    logic        m_op_fault;
    logic        m_addr_fault;
    logic        m_access_fault;

    modport slave (
        input  req0_valid, req0_write, req0_signed, req0_size, req0_addr, req0_wdata,
        output req0_ready, req0_done, req0_rdata, req0_fault,
        input  req1_valid, req1_write, req1_signed, req1_size, req1_addr, req1_wdata,
        output req1_ready, req1_done, req1_rdata, req1_fault,
        output m_en, m_write, m_signed, m_size, m_addr, m_wdata,
        input  m_rdata, m_busy, m_op_fault, m_addr_fault, m_access_fault
    );

    modport master (
        output req0_valid, req0_write, req0_signed, req0_size, req0_addr, req0_wdata,
        input  req0_ready, req0_done, req0_rdata, req0_fault,
        output req1_valid, req1_write, req1_signed, req1_size, req1_addr, req1_wdata,
        input  req1_ready, req1_done, req1_rdata, req1_fault,
        input  m_en, m_write, m_signed, m_size, m_addr, m_wdata,
        output m_rdata, m_busy, m_op_fault, m_addr_fault, m_access_fault
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the single memory port: fixed priority with starvation guard,
// one transaction in flight, optional timeout for a hung memory.
module mem_port_arbiter #(
    parameter int unsigned PRIO_PORT      = 0,
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned StW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int unsigned TmW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [StW-1:0] StarveMax = StW'(STARVE_LIMIT);
    // With the timeout disabled the counter only needs to mark "not first BUSY cycle".
    localparam logic [TmW-1:0] TmoMax  = (TIMEOUT_CYCLES > 0) ? TmW'(TIMEOUT_CYCLES) : TmW'(1);
    localparam logic [TmW-1:0] TmoLast = (TIMEOUT_CYCLES > 0) ? TmW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic           PrioPort = PRIO_PORT[0];

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic             write_q, write_d;
    logic             signed_q, signed_d;
    logic [1:0]       size_q, size_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [StW-1:0]   starve_q, starve_d;
    logic [TmW-1:0]   tmo_q, tmo_d;
    logic [1:0]       ready_q, ready_d;
    logic [1:0]       done_q, done_d;
    logic [1:0][31:0] rdata_q, rdata_d;
    logic [1:0][2:0]  fault_q, fault_d;

    logic v0, v1, both, grant, busy;

    assign v0   = bus.req0_valid;
    assign v1   = bus.req1_valid;
    assign both = v0 & v1;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        write_d  = write_q;
        signed_d = signed_q;
        size_d   = size_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        starve_d = starve_q;
        tmo_d    = tmo_q;
        ready_d  = '0;
        done_d   = '0;
        rdata_d  = rdata_q;
        fault_d  = fault_q;
        grant    = 1'b0;

        unique case (state_q)
            StIdle: begin
                tmo_d = '0;
                if (both) begin
                    grant = (STARVE_LIMIT != 0 && starve_q == StarveMax) ? ~PrioPort : PrioPort;
                end else begin
                    grant = v1;
                end
                if (v0 | v1) begin
                    owner_d        = grant;
                    write_d        = grant ? bus.req1_write  : bus.req0_write;
                    signed_d       = grant ? bus.req1_signed : bus.req0_signed;
                    size_d         = grant ? bus.req1_size   : bus.req0_size;
                    addr_d         = grant ? bus.req1_addr   : bus.req0_addr;
                    wdata_d        = grant ? bus.req1_wdata  : bus.req0_wdata;
                    ready_d[grant] = 1'b1;
                    state_d        = StBusy;
                end
                // Count only priority wins taken while the other port was waiting.
                if (both && grant == PrioPort) begin
                    if (starve_q != StarveMax) starve_d = starve_q + StW'(1);
                end else begin
                    starve_d = '0;
                end
            end
            StBusy: begin
                if (tmo_q != '0 && !bus.m_busy) begin
                    state_d          = StResp;
                    done_d[owner_q]  = 1'b1;
                    rdata_d[owner_q] = bus.m_rdata;
                    fault_d[owner_q] = {bus.m_op_fault, bus.m_addr_fault, bus.m_access_fault};
                end else if (TIMEOUT_CYCLES != 0 && tmo_q == TmoLast) begin
                    state_d          = StResp;
                    done_d[owner_q]  = 1'b1;
                    rdata_d[owner_q] = '0;
                    fault_d[owner_q] = 3'b001;
                end else if (tmo_q != TmoMax) begin
                    tmo_d = tmo_q + TmW'(1);
                end
            end
            StResp: begin
                tmo_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            owner_q  <= 1'b0;
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            size_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            starve_q <= '0;
            tmo_q    <= '0;
            ready_q  <= '0;
            done_q   <= '0;
            rdata_q  <= '0;
            fault_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            write_q  <= write_d;
            signed_q <= signed_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            starve_q <= starve_d;
            tmo_q    <= tmo_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
        end
    end

    // Memory command comes only from latched fields, gated by BUSY.
    assign busy         = (state_q == StBusy);
    assign bus.m_en     = busy;
    assign bus.m_write  = busy & write_q;
    assign bus.m_signed = busy & signed_q;
    assign bus.m_size   = busy ? size_q  : 2'b00;
    assign bus.m_addr   = busy ? addr_q  : 32'h0;
    assign bus.m_wdata  = busy ? wdata_q : 32'h0;

    assign bus.req0_ready = ready_q[0];
    assign bus.req1_ready = ready_q[1];
    assign bus.req0_done  = done_q[0];
    assign bus.req1_done  = done_q[1];
    assign bus.req0_rdata = rdata_q[0];
    assign bus.req1_rdata = rdata_q[1];
    assign bus.req0_fault = fault_q[0];
    assign bus.req1_fault = fault_q[1];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter against a transaction-level model
// of arbitration, memory latency, timeout and per-port response hold.
module tb_mem_port_arbiter;

    localparam int unsigned Limit = 4;
    localparam int unsigned Tmo   = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .PRIO_PORT     (0),
        .STARVE_LIMIT  (Limit),
        .TIMEOUT_CYCLES(Tmo)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Requester-side state, one entry per port.
    logic        rv[2];
    logic        rw[2];
    logic        rs[2];
    logic [1:0]  rsz[2];
    logic [31:0] ra[2];
    logic [31:0] rwd[2];

    // Model: arbitration history (1 = priority port won while port 1 waited) and
    // last response delivered to each port.
    bit          hist[$];
    logic [31:0] exp_rd[2];
    logic [2:0]  exp_ft[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int p);
        return p != 0 ? bus.req1_ready : bus.req0_ready;
    endfunction
    function automatic logic dn(input int p);
        return p != 0 ? bus.req1_done : bus.req0_done;
    endfunction
    function automatic logic [31:0] rdat(input int p);
        return p != 0 ? bus.req1_rdata : bus.req0_rdata;
    endfunction
    function automatic logic [2:0] flt(input int p);
        return p != 0 ? bus.req1_fault : bus.req0_fault;
    endfunction

    function automatic int trailing_prio();
        int n = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (!hist[i]) break;
            n++;
        end
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req();
        bus.req0_valid  = rv[0];
        bus.req0_write  = rw[0];
        bus.req0_signed = rs[0];
        bus.req0_size   = rsz[0];
        bus.req0_addr   = ra[0];
        bus.req0_wdata  = rwd[0];
        bus.req1_valid  = rv[1];
        bus.req1_write  = rw[1];
        bus.req1_signed = rs[1];
        bus.req1_size   = rsz[1];
        bus.req1_addr   = ra[1];
        bus.req1_wdata  = rwd[1];
    endtask

    task automatic raise(input int p);
        rv[p]  = 1'b1;
        rw[p]  = 1'($urandom_range(0, 1));
        rs[p]  = 1'($urandom_range(0, 1));
        rsz[p] = 2'($urandom_range(0, 3));
        ra[p]  = $urandom;
        rwd[p] = $urandom;
    endtask

    task automatic model_reset();
        hist.delete();
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        exp_ft[0] = '0;
        exp_ft[1] = '0;
    endtask

    // One full transaction starting in an IDLE cycle; ends in the following IDLE cycle.
    // lat = number of BUSY cycles the memory reports busy.
    task automatic txn(input int lat, input logic [31:0] mrd, input logic [2:0] mft);
        int          g, nb;
        bit          both, timed;
        logic        ew, es;
        logic [1:0]  esz;
        logic [31:0] ea, ewd;

        both = rv[0] && rv[1];
        if (both) g = (trailing_prio() >= Limit) ? 1 : 0;
        else      g = rv[1] ? 1 : 0;
        hist.push_back(both && g == 0);
        ew = rw[g]; es = rs[g]; esz = rsz[g]; ea = ra[g]; ewd = rwd[g];

        drive_req();
        tick();
        chk($sformatf("ready_grant_p%0d", g), rdy(g), 1'b1);
        chk("ready_other", rdy(1 - g), 1'b0);
        chk("m_en_first", bus.m_en, 1'b1);
        chk("m_addr", bus.m_addr, ea);
        chk("m_wdata", bus.m_wdata, ewd);
        chk("m_write", bus.m_write, ew);
        chk("m_signed", bus.m_signed, es);
        chk("m_size", bus.m_size, esz);

        // Requester sees ready: drops valid and scribbles its fields.
        rv[g]  = 1'b0;
        ra[g]  = $urandom;
        rwd[g] = $urandom;
        drive_req();

        nb    = (lat + 1 < 2) ? 2 : lat + 1;
        timed = nb > int'(Tmo);
        if (timed) nb = Tmo;
        for (int k = 1; k <= nb; k++) begin
            bus.m_busy         = (k <= lat);
            bus.m_rdata        = mrd;
            bus.m_op_fault     = mft[2];
            bus.m_addr_fault   = mft[1];
            bus.m_access_fault = mft[0];
            tick();
            if (k < nb) begin
                chk("busy_m_en", bus.m_en, 1'b1);
                chk("busy_m_addr_latched", bus.m_addr, ea);
                chk("busy_no_done", {dn(1), dn(0), rdy(g)}, 3'b000);
            end
        end

        exp_rd[g] = timed ? 32'h0 : mrd;
        exp_ft[g] = timed ? 3'b001 : mft;
        chk("resp_done_owner", dn(g), 1'b1);
        chk("resp_done_other", dn(1 - g), 1'b0);
        chk("resp_rdata", rdat(g), exp_rd[g]);
        chk("resp_fault", flt(g), exp_ft[g]);
        chk("resp_other_rdata_hold", rdat(1 - g), exp_rd[1 - g]);
        chk("resp_other_fault_hold", flt(1 - g), exp_ft[1 - g]);
        chk("resp_m_en", bus.m_en, 1'b0);

        bus.m_busy = 1'b0;
        tick();
        chk("idle_done_clear", dn(g), 1'b0);
        chk("idle_m_en", bus.m_en, 1'b0);
        chk("idle_rdata_hold", rdat(g), exp_rd[g]);
    endtask

    initial begin
        for (int p = 0; p < 2; p++) begin
            rv[p] = 0; rw[p] = 0; rs[p] = 0; rsz[p] = 0; ra[p] = 0; rwd[p] = 0;
        end
        bus.m_rdata = '0; bus.m_busy = 1'b0;
        bus.m_op_fault = 1'b0; bus.m_addr_fault = 1'b0; bus.m_access_fault = 1'b0;
        model_reset();

        // Reset held with a pending port-0 word load at 0x100.
        rv[0] = 1; rw[0] = 0; rs[0] = 0; rsz[0] = 2'b10; ra[0] = 32'h100; rwd[0] = 32'h0;
        drive_req();
        reset = 1'b0;
        repeat (3) begin
            tick();
            chk("rst_ready", {rdy(1), rdy(0)}, 2'b00);
            chk("rst_done", {dn(1), dn(0)}, 2'b00);
            chk("rst_m_en", bus.m_en, 1'b0);
            chk("rst_rdata0", rdat(0), 32'h0);
            chk("rst_fault1", flt(1), 3'b000);
        end
        reset = 1'b1;
        txn(3, 32'hDEADBEEF, 3'b000);

        // Both ports continuously valid: expect 0,0,0,0,1 repeating.
        for (int i = 0; i < 10; i++) begin
            for (int p = 0; p < 2; p++) if (!rv[p]) raise(p);
            txn($urandom_range(0, 3), $urandom, 3'b000);
        end
        txn(1, $urandom, 3'b000);

        // Port-1 store with address fault, then a normal port-0 request.
        rv[1] = 1; rw[1] = 1; rs[1] = 0; rsz[1] = 2'b10; ra[1] = 32'h2000; rwd[1] = 32'h1234;
        txn(2, $urandom, 3'b010);
        raise(0);
        txn(1, 32'hA5A5_0001, 3'b000);

        // Hung memory: timeout after Tmo BUSY cycles.
        raise(0);
        txn(50, 32'hFFFF_FFFF, 3'b000);

        // Reset in the middle of a transaction.
        raise(1);
        drive_req();
        tick();
        chk("mid_ready1", rdy(1), 1'b1);
        rv[1] = 1'b0;
        drive_req();
        bus.m_busy = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("mid_rst_m_en", bus.m_en, 1'b0);
        chk("mid_rst_done", {dn(1), dn(0)}, 2'b00);
        reset = 1'b1;
        model_reset();
        bus.m_busy = 1'b0;
        tick();
        hist.push_back(1'b0);
        chk("mid_rst_no_done", {dn(1), dn(0)}, 2'b00);
        chk("mid_rst_rdata0", rdat(0), 32'h0);
        raise(1);
        txn(0, $urandom, 3'b100);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            if (!rv[0] && !rv[1]) begin
                repeat ($urandom_range(0, 2)) begin
                    tick();
                    hist.push_back(1'b0);
                end
            end
            for (int p = 0; p < 2; p++) if (!rv[p] && $urandom_range(0, 1) == 1) raise(p);
            if (!rv[0] && !rv[1]) raise($urandom_range(0, 1));
            txn($urandom_range(0, 9), $urandom, 3'($urandom_range(0, 7)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
